// File: rtl/afe_spi_responder_pkg.sv
// Shared definitions for the AFE SPI responder.
//   - State encodings for the frame FSM (IDLE / SHIFT / LATCH).
//   - Default word width.
//   - Width helpers for the bit counter and the SHIFT timeout counter.
package afe_spi_responder_pkg;

  localparam int unsigned DEFAULT_WORD_WIDTH = 24;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_LATCH = 2'd2;

  // The bit counter saturates at word_width+1, so it needs to hold 0..word_width+1.
  function automatic int unsigned bit_count_w(input int unsigned word_width);
    return $clog2(word_width + 2);
  endfunction

  // The timeout counter runs 0..timeout-1; keep at least one bit when disabled.
  function automatic int unsigned timeout_cnt_w(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/afe_spi_responder_sync_edge_detect.sv
// Synchroniser plus registered edge detector for one asynchronous input.
// Ports:
//   clk_i    system clock
//   rst_n_i  synchronous active-low reset
//   async_i  asynchronous input pin
//   level_o  synchronised level, aligned with rise_o/fall_o
//   rise_o   one-cycle pulse on a synchronised 0->1 transition
//   fall_o   one-cycle pulse on a synchronised 1->0 transition
module afe_spi_responder_sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 3,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rise_q;
  logic                   fall_q;

  // Edges compare the last two synchroniser stages and are registered, so
  // after the update sync_q[SYNC_STAGES-1] already holds the post-edge level.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      rise_q <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
      fall_q <= ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/afe_spi_responder.sv
// SPI-style responder for the AFE attenuator link (CLK/SDI/LE). Oversamples the
// asynchronous pins in the sysClk domain, deserialises MSB-first frames, latches
// the word on LE rise and flags bad bit counts or a stalled clock.
// Optional feature macro: AFE_SPI_RESPONDER_READBACK_EN (shift previous good
// word out on spiSdo during each frame); when undefined spiSdo is tied low.
// Ports:
//   sysClk      system clock          sysReset_n  sync active-low reset
//   spiClk      async serial clock    spiSdi      async serial data
//   spiLe       async latch enable (low = frame active)
//   spiSdo      readback data         wordData    last correctly framed word
//   wordValid   strobe, new wordData  frameError  strobe, bad count or timeout
//   busy        high while in SHIFT   frameCount  good-frame count (wraps)
module afe_spi_responder
  import afe_spi_responder_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = DEFAULT_WORD_WIDTH,
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  sysClk,
  input  logic                  sysReset_n,
  input  logic                  spiClk,
  input  logic                  spiSdi,
  input  logic                  spiLe,
  output logic                  spiSdo,
  output logic [WORD_WIDTH-1:0] wordData,
  output logic                  wordValid,
  output logic                  frameError,
  output logic                  busy,
  output logic [15:0]           frameCount
);

  localparam int unsigned    CW       = bit_count_w(WORD_WIDTH);
  localparam int unsigned    TW       = timeout_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  FULL_CNT = CW'(WORD_WIDTH);
  localparam logic [CW-1:0]  SAT_CNT  = CW'(WORD_WIDTH + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit             TMO_EN   = (TIMEOUT_CYCLES != 0);

  logic clk_lvl, clk_rise, clk_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;
  logic le_lvl,  le_rise,  le_fall;

  afe_spi_responder_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .clk_i(sysClk), .rst_n_i(sysReset_n), .async_i(spiClk),
    .level_o(clk_lvl), .rise_o(clk_rise), .fall_o(clk_fall)
  );

  afe_spi_responder_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk_i(sysClk), .rst_n_i(sysReset_n), .async_i(spiSdi),
    .level_o(sdi_lvl), .rise_o(sdi_rise), .fall_o(sdi_fall)
  );

  // LE idles high, so its synchroniser resets high to avoid a false frame start.
  afe_spi_responder_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_le (
    .clk_i(sysClk), .rst_n_i(sysReset_n), .async_i(spiLe),
    .level_o(le_lvl), .rise_o(le_rise), .fall_o(le_fall)
  );

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [15:0]           fcnt_q, fcnt_d;
  logic                  pend_q, pend_d;
  logic                  enter;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tmo_d   = tmo_q;
    word_d  = word_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    fcnt_d  = fcnt_q;
    pend_d  = 1'b0;
    enter   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // pend_q carries an LE fall that arrived while the FSM sat in LATCH.
        if (le_fall || pend_q) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          tmo_d   = '0;
          enter   = 1'b1;
        end
      end
      ST_SHIFT: begin
        // LE rise has priority over a coincident CLK rise: that bit is dropped.
        if (le_rise) begin
          state_d = ST_LATCH;
        end else if (clk_rise) begin
          shift_d = {shift_q[WORD_WIDTH-2:0], sdi_lvl};
          if (cnt_q != SAT_CNT) cnt_d = cnt_q + 1'b1;
          tmo_d = '0;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_LATCH: begin
        state_d = ST_IDLE;
        pend_d  = le_fall;
        if (cnt_q == FULL_CNT) begin
          word_d  = shift_q;
          valid_d = 1'b1;
          fcnt_d  = fcnt_q + 16'd1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      tmo_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      tmo_q   <= tmo_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
    end
  end

`ifdef AFE_SPI_RESPONDER_READBACK_EN
  logic [WORD_WIDTH-1:0] rb_q, rb_d;
  logic                  sdo_q, sdo_d;

  // MSB is presented at frame start; each CLK fall advances one bit, and
  // zeros fill in behind the LSB. Outside SHIFT the pin is held low.
  always_comb begin
    rb_d  = rb_q;
    sdo_d = 1'b0;
    if (enter) begin
      sdo_d = word_q[WORD_WIDTH-1];
      rb_d  = {word_q[WORD_WIDTH-2:0], 1'b0};
    end else if ((state_q == ST_SHIFT) && (state_d == ST_SHIFT)) begin
      sdo_d = sdo_q;
      if (clk_fall) begin
        sdo_d = rb_q[WORD_WIDTH-1];
        rb_d  = {rb_q[WORD_WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      rb_q  <= '0;
      sdo_q <= 1'b0;
    end else begin
      rb_q  <= rb_d;
      sdo_q <= sdo_d;
    end
  end

  assign spiSdo = sdo_q;
`else
  assign spiSdo = 1'b0;
`endif

  logic unused_sigs;
  assign unused_sigs = ^{clk_lvl, clk_fall, sdi_rise, sdi_fall, le_lvl, enter};

  assign wordData   = word_q;
  assign wordValid  = valid_q;
  assign frameError = err_q;
  assign busy       = (state_q == ST_SHIFT);
  assign frameCount = fcnt_q;

endmodule
